// File: rtl/thumb_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thumb_seq_pkg
// Purpose  : Shared types and constants for the Thumb LDM/STM/PUSH/POP
//            sequencer: state encoding, bus size code, special register
//            ids and a 9-bit population count helper.
// Revision : 1.0 - initial release
// ============================================================================
package thumb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_t;

  localparam logic [1:0] BUS_SIZE_WORD = 2'b10;

  localparam logic [4:0] REG_SP = 5'h0d;
  localparam logic [4:0] REG_LR = 5'h0e;
  localparam logic [4:0] REG_PC = 5'h0f;

  // Number of registers named by a 9-bit transfer mask (r0-r7 plus LR/PC).
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/thumb_ldm_stm_seq_lsb_enc.sv
`default_nettype none
// ============================================================================
// Module   : seq_lsb_enc
// Purpose  : 9-bit lowest-set-bit encoder. Returns the index of the lowest
//            set bit and a one-hot mask selecting it (all zero when the
//            input is empty).
// Revision : 1.0 - initial release
// ============================================================================
module seq_lsb_enc (
  input  logic [8:0] vec,
  output logic [3:0] idx,
  output logic [8:0] onehot
);

  // Isolate the lowest set bit with two's complement, then encode it.
  always_comb begin
    onehot = vec & (~vec + 9'd1);
    idx    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (onehot[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/thumb_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : thumb_ldm_stm_seq
// Purpose  : Multi-cycle sequencer for Thumb LDM/STM/PUSH/POP. Expands the
//            register list into one word beat per register (lowest register
//            at lowest address), stalls the pipeline via busy, then issues
//            the base writeback, POP-to-PC branch and done pulses.
// Options  : THUMB_SEQ_EMPTY_TRAP_EN - when defined an empty register list
//            raises undef alongside done; otherwise undef is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module thumb_ldm_stm_seq
  import thumb_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_load,
  input  logic              op_stack,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              reg_extra,
  input  logic [3:0]        base_id,
  input  logic [ADDR_W-1:0] base_val,
  input  logic              bus_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr_en,
  output logic              bus_rd_en,
  output logic [1:0]        bus_size,
  output logic [4:0]        xfer_reg,
  output logic              wb_en,
  output logic [4:0]        wb_id,
  output logic [ADDR_W-1:0] wb_val,
  output logic              branch,
  output logic              done,
  output logic              undef
);

  seq_state_t        state, state_nx;

  logic [8:0]        mask;
  logic [3:0]        count;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base;
  logic [3:0]        base_id_q;
  logic              op_load_q;
  logic              op_stack_q;
  logic              ldm_base_hit;
  logic              pop_pc;

  logic [7:0]        list8;
  logic [8:0]        new_mask;
  logic [3:0]        new_cnt;
  logic [ADDR_W-1:0] new_four_n;
  logic [ADDR_W-1:0] four_n;
  logic [3:0]        lsb_idx;
  logic [8:0]        lsb_onehot;

  assign list8      = 8'(reg_list);
  // Bit 8 stands for LR on a PUSH and PC on a POP; plain LDM/STM never use it.
  assign new_mask   = {reg_extra & op_stack, list8};
  assign new_cnt    = popcount9(new_mask);
  assign new_four_n = {{(ADDR_W-6){1'b0}}, new_cnt, 2'b00};
  assign four_n     = {{(ADDR_W-6){1'b0}}, count, 2'b00};

  seq_lsb_enc u_lsb_enc (
    .vec    (mask),
    .idx    (lsb_idx),
    .onehot (lsb_onehot)
  );

  // State register plus the operands latched at start and walked during XFER.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mask         <= 9'd0;
      count        <= 4'd0;
      addr         <= '0;
      base         <= '0;
      base_id_q    <= 4'd0;
      op_load_q    <= 1'b0;
      op_stack_q   <= 1'b0;
      ldm_base_hit <= 1'b0;
      pop_pc       <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask         <= new_mask;
            count        <= new_cnt;
            base         <= base_val;
            base_id_q    <= op_stack ? REG_SP[3:0] : base_id;
            // PUSH is full-descending: the block starts 4n below SP.
            addr         <= (op_stack & ~op_load) ? (base_val - new_four_n) : base_val;
            op_load_q    <= op_load;
            op_stack_q   <= op_stack;
            // A load into the base register wins over the writeback.
            ldm_base_hit <= op_load & ~op_stack & ~base_id[3] & list8[base_id[2:0]];
            pop_pc       <= op_load & op_stack & reg_extra;
          end
        end
        ST_XFER: begin
          if (bus_ready) begin
            mask <= mask & ~lsb_onehot;
            addr <= addr + ADDR_W'(4);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode and all outputs; everything idles at zero outside its phase.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    bus_addr  = '0;
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    bus_size  = 2'b00;
    xfer_reg  = 5'd0;
    wb_en     = 1'b0;
    wb_id     = 5'd0;
    wb_val    = '0;
    branch    = 1'b0;
    done      = 1'b0;
    undef     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (new_cnt != 4'd0) ? ST_XFER : ST_FIN;
        end
      end
      ST_XFER: begin
        busy      = 1'b1;
        bus_wr_en = ~op_load_q;
        bus_rd_en = op_load_q;
        bus_size  = BUS_SIZE_WORD;
        bus_addr  = addr;
        xfer_reg  = lsb_idx[3] ? (op_load_q ? REG_PC : REG_LR) : {2'b00, lsb_idx[2:0]};
        if (bus_ready && (mask == lsb_onehot)) begin
          state_nx = ST_FIN;
        end
      end
      ST_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        wb_en    = (count != 4'd0) & ~ldm_base_hit;
        wb_id    = {1'b0, base_id_q};
        wb_val   = (op_stack_q & ~op_load_q) ? (base - four_n) : (base + four_n);
        branch   = pop_pc;
`ifdef THUMB_SEQ_EMPTY_TRAP_EN
        undef    = (count == 4'd0);
`else
        undef    = 1'b0;
`endif
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/thumb_ldm_stm_seq.md
Name: thumb_ldm_stm_seq

Overview:
- Multi-cycle sequencer for Thumb block transfers: LDM, STM, PUSH and POP.
- Sits beside the Thumb standard decoder. When the decoder flags one of these four instructions, the pipeline hands the register list and base value to this block.
- The block expands the list into one word-sized bus beat per register and stalls the pipeline while it runs.
- It finishes with an optional base-register writeback and, for POP with PC in the list, a branch pulse.

Parameters:
- ADDR_W, 32, bus address / register data width.
- LIST_W, 8, width of the low-register list (r0–r7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- op_load  in  1  1 = LDM/POP (read), 0 = STM/PUSH (write).
- op_stack  in  1  1 = PUSH/POP: base fixed to r13, reg_extra meaningful.
- reg_list  in  LIST_W  register list; bit i = ri.
- reg_extra  in  1  PUSH: include r14; POP: include r15.
- base_id  in  4  base register id (ignored when op_stack=1, which forces 13).
- base_val  in  ADDR_W  base register value, sampled at start.
- bus_ready  in  1  current beat accepted this cycle.
- busy  out  1  high in every state except IDLE; used as the pipeline stall.
- bus_addr  out  ADDR_W  address of the current beat.
- bus_wr_en  out  1  store beat valid.
- bus_rd_en  out  1  load beat valid.
- bus_size  out  2  2'b10 (word) whenever a beat is valid, else 0.
- xfer_reg  out  5  register id for the current beat: source for a store, destination for a load.
- wb_en  out  1  one-cycle base writeback.
- wb_id  out  5  writeback register id.
- wb_val  out  ADDR_W  writeback value.
- branch  out  1  one-cycle pulse: PC loaded by POP, flush the pipeline.
- done  out  1  one-cycle completion pulse.
- undef  out  1  one-cycle empty-list trap (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - All outputs are 0, including bus_addr, xfer_reg and wb_val.
  - Internal mask, count and address registers are 0.
- Reset asserted mid-operation aborts immediately. A pending beat is dropped; no writeback, done or branch is issued.
- States: IDLE, XFER, FIN.
- IDLE:
  - On start, latch the following:
    - mask = {reg_extra & op_stack, reg_list}, bit 8 mapped to r14 (store) or r15 (load).
    - n = popcount(mask).
    - base and base_id.
    - first address: op_stack & ~op_load gives base − 4n; all other cases give base.
  - n>0: go to XFER. n==0: go to FIN.
  - start while busy is ignored.
- XFER:
  - The beat comes from the lowest set mask bit, so addresses ascend and lower registers sit at lower addresses.
  - bus_wr_en or bus_rd_en is asserted, with bus_addr and xfer_reg from that bit.
  - All beat outputs stay stable while bus_ready=0.
  - On bus_ready=1: clear that mask bit and add 4 to the address. If it was the last bit, go to FIN.
- FIN, one cycle, then back to IDLE:
  - done=1.
  - Writeback value: PUSH gives base − 4n; all others give base + 4n.
  - wb_en=1, wb_id={0,base_id}, except:
    - LDM (op_load & ~op_stack) with base_id in the list gives wb_en=0.
    - n==0 gives wb_en=0.
  - branch=1 iff op_load & op_stack & mask bit 8.
- Latency: start at cycle 0; first beat visible at cycle 1. With bus_ready held high, done is at cycle n+1.
- Arithmetic: address math is modulo 2^ADDR_W, so wrap-around is silent.
- STM with base in the list stores the value sampled at start.

Optional Feature:
- Macro: THUMB_SEQ_EMPTY_TRAP_EN.
- Defined: n==0 gives undef=1 together with done in FIN; no beats and no writeback.
- Undefined: undef is tied 0; an empty list completes as a no-op in 2 cycles.

Decomposition:
- Package thumb_seq_pkg holds:
  - the state enum (IDLE/XFER/FIN);
  - BUS_SIZE_WORD=2'b10;
  - REG_SP=5'h0d, REG_LR=5'h0e, REG_PC=5'h0f;
  - a popcount function over 9 bits.
- One sub-module, seq_lsb_enc: 9-bit lowest-set-bit encoder giving index plus one-hot clear mask.

Test Plan:
- PUSH {r0,r4,LR}, r13=0x1000, ready=1:
  - writes r0@0x0FF4, r4@0x0FF8, r14@0x0FFC on cycles 1–3;
  - cycle 4: done, wb_en, wb_id=13, wb_val=0x0FF4.
- POP {r1,PC}, r13=0x0FF8:
  - reads r1@0x0FF8, r15@0x0FFC;
  - FIN: wb_val=0x1000, branch=1, done=1.
- LDM r2!,{r2,r3}, base 0x2000: reads r2@0x2000, r3@0x2004; FIN with wb_en=0.
- STM r0!,{r5}, base 0x3000, bus_ready low 3 cycles:
  - wr_en, addr 0x3000 and xfer_reg=5 held 4 cycles;
  - done on cycle 5, wb_val=0x3004.
- rst_n=0 during the second beat of a 3-register LDM:
  - next cycle all outputs 0 and state IDLE;
  - a start during busy in a separate run has no effect.
- reg_list=0, reg_extra=0:
  - done at cycle 1, no bus beat, wb_en=0;
  - undef=1 only with THUMB_SEQ_EMPTY_TRAP_EN.
